// File: rtl/bsg_cover_pkg.sv
// bsg_cover_pkg: shared types for the coverage-stream arbiter
// Holds the arbiter FSM state encoding and the default header layout.
package bsg_cover_pkg;
  localparam int id_width_c  = 8;
  localparam int els_width_c = 8;
  localparam int len_width_c = 8;
  // Header beat layout: id in the MSBs, then element count, then beats-per-entry.
  typedef struct packed {
    logic [id_width_c-1:0]  id;
    logic [els_width_c-1:0] els;
    logic [len_width_c-1:0] len;
  } bsg_cover_hdr_s;
  typedef enum logic [1:0] {st_idle, st_hdr, st_data, st_term} state_e;
endpackage

// File: rtl/bsg_cover_arbiter_if.sv
// bsg_cover_arbiter_if: cover-side and downstream signals of the coverage arbiter
// master = arbiter side, slave = covers plus downstream consumer.
interface bsg_cover_arbiter_if #(
  parameter int num_cover_p = 4,
  parameter int out_width_p = 32,
  parameter int id_width_p  = 8,
  parameter int els_width_p = 8,
  parameter int len_width_p = 8
);
  logic                               drain_req_i;
  logic [num_cover_p-1:0]             drain_o;
  logic [num_cover_p-1:0]             gate_i;
  logic                               gate_o;
  logic                               drain_done_o;
  logic [num_cover_p-1:0]             id_v_i;
  logic [num_cover_p*id_width_p-1:0]  id_i;
  logic [num_cover_p*els_width_p-1:0] els_i;
  logic [num_cover_p*len_width_p-1:0] len_i;
  logic [num_cover_p-1:0]             v_i;
  logic [num_cover_p-1:0]             last_i;
  logic [num_cover_p*out_width_p-1:0] data_i;
  logic [num_cover_p-1:0]             ready_o;
  logic                               v_o;
  logic [out_width_p-1:0]             data_o;
  logic                               last_o;
  logic                               ready_i;
  logic                               busy_o;
  modport master (
    input  drain_req_i, gate_i, id_v_i, id_i, els_i, len_i, v_i, last_i, data_i, ready_i,
    output drain_o, gate_o, drain_done_o, ready_o, v_o, data_o, last_o, busy_o
  );
  modport slave (
    output drain_req_i, gate_i, id_v_i, id_i, els_i, len_i, v_i, last_i, data_i, ready_i,
    input  drain_o, gate_o, drain_done_o, ready_o, v_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: round-robin picker; search starts at the index after the last accepted grant
// Ports: clk, rst, req (requests), yumi (grant accepted), v (any request), grant (index).
module bsg_arb_round_robin #(
  parameter int width_p = 4,
  localparam int lg_lp = width_p > 1 ? $clog2(width_p) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [width_p-1:0] req,
  input  logic               yumi,
  output logic               v,
  output logic [lg_lp-1:0]   grant
);
  logic [lg_lp-1:0] ptr_r;
  assign v = |req;
  // Walk downward so the closest request to ptr_r is assigned last and wins.
  always_comb begin
    grant = '0;
    for (int k = width_p - 1; k >= 0; k--)
      if (req[(int'(ptr_r) + k) % width_p]) grant = lg_lp'((int'(ptr_r) + k) % width_p);
  end
  always_ff @(posedge clk)
    if (rst) ptr_r <= '0;
    else if (yumi) ptr_r <= lg_lp'((int'(grant) + 1) % width_p);
endmodule

// File: rtl/bsg_cover_arbiter.sv
// bsg_cover_arbiter: shares one downstream coverage stream among num_cover_p covers
// Ports: clk_i/reset_i (sync, active-high); bus.master carries drain/gate control,
// per-cover header and data streams, and the downstream valid/ready stream.
module bsg_cover_arbiter
  import bsg_cover_pkg::*;
#(
  parameter int num_cover_p = 4,
  parameter int out_width_p = 32,
  parameter int id_width_p  = 8,
  parameter int els_width_p = 8,
  parameter int len_width_p = 8
) (
  input logic                 clk_i,
  input logic                 reset_i,
  bsg_cover_arbiter_if.master bus
);
  localparam int lg_lp  = num_cover_p > 1 ? $clog2(num_cover_p) : 1;
  localparam int hdr_lp = id_width_p + els_width_p + len_width_p;
  localparam logic [1:0] IDLE = st_idle;
  localparam logic [1:0] HDR  = st_hdr;
  localparam logic [1:0] DATA = st_data;
  localparam logic [1:0] TERM = st_term;
  logic [1:0]             state_r, state_n;
  logic [lg_lp-1:0]       g_r, rr_grant;
  logic                   rr_v, yumi, done;
  logic [num_cover_p-1:0] pending_r, g_onehot;
  logic                   drain_active_r;
  logic [hdr_lp-1:0]      hdr;
  logic                   in_hdr, in_data, in_term;
  bsg_arb_round_robin #(.width_p(num_cover_p)) rr (
    .clk(clk_i), .rst(reset_i), .req(bus.id_v_i), .yumi(yumi), .v(rr_v), .grant(rr_grant)
  );
  assign yumi     = state_r == IDLE && rr_v;
  assign in_hdr   = state_r == HDR;
  assign in_data  = state_r == DATA;
  assign in_term  = state_r == TERM;
  assign g_onehot = num_cover_p'(1) << g_r;
  assign hdr = {bus.id_i[g_r*id_width_p +: id_width_p],
                bus.els_i[g_r*els_width_p +: els_width_p],
                bus.len_i[g_r*len_width_p +: len_width_p]};
  assign bus.v_o     = in_hdr ? bus.id_v_i[g_r] : in_data ? bus.v_i[g_r] : in_term;
  assign bus.data_o  = in_hdr ? out_width_p'(hdr) : in_data ? bus.data_i[g_r*out_width_p +: out_width_p] : '0;
  assign bus.last_o  = in_data ? bus.last_i[g_r] : in_term;
  assign bus.ready_o = (in_hdr || in_data) && bus.ready_i ? g_onehot : '0;
  assign bus.busy_o  = state_r != IDLE;
  assign bus.drain_o = pending_r & ~bus.gate_i;
  assign bus.gate_o  = |bus.gate_i | drain_active_r;
  // Drain completes only once every cover has been served and is back in fill.
  assign done = drain_active_r && pending_r == '0 && bus.gate_i == '0 && state_r == IDLE;
  assign bus.drain_done_o = done;
  // Last beat outranks the cover dropping its gate in the same cycle.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: state_n = rr_v ? HDR : IDLE;
      HDR:  state_n = bus.id_v_i[g_r] && bus.ready_i ? DATA : HDR;
      DATA: state_n = bus.v_i[g_r] && bus.last_i[g_r] && bus.ready_i ? IDLE : !bus.gate_i[g_r] ? TERM : DATA;
      default: state_n = bus.ready_i ? IDLE : TERM;
    endcase
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r        <= IDLE;
      g_r            <= '0;
      pending_r      <= '0;
      drain_active_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (yumi) g_r <= rr_grant;
      if (!drain_active_r) begin
        if (bus.drain_req_i) begin
          drain_active_r <= 1'b1;
          pending_r      <= '1;
        end
      end else begin
        pending_r <= pending_r & ~bus.gate_i;
        if (done) drain_active_r <= 1'b0;
      end
    end
endmodule

// File: tb/tb_bsg_cover_arbiter.sv
// tb_bsg_cover_arbiter: directed self-checking bench for bsg_cover_arbiter
module tb_bsg_cover_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int passed = 0;
  int total = 0;
  bsg_cover_arbiter_if bus ();
  bsg_cover_arbiter dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.drain_req_i = 1'b0; bus.gate_i = '0; bus.id_v_i = '0; bus.id_i = '0; bus.els_i = '0;
    bus.len_i = '0; bus.v_i = '0; bus.last_i = '0; bus.data_i = '0; bus.ready_i = 1'b1;
  endtask
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic set_hdr(input int i, input logic [7:0] id, input logic [7:0] els, input logic [7:0] len);
    bus.id_i[i*8 +: 8] = id;
    bus.els_i[i*8 +: 8] = els;
    bus.len_i[i*8 +: 8] = len;
  endtask
  task automatic test_reset();
    clear_inputs();
    bus.gate_i = 4'b0101;
    rst = 1'b1;
    step();
    step();
    total++; if (bus.v_o !== 1'b0) $display("FAIL rst_v got %0h exp 0", bus.v_o); else passed++;
    total++; if (bus.last_o !== 1'b0) $display("FAIL rst_last got %0h exp 0", bus.last_o); else passed++;
    total++; if (bus.data_o !== 32'h0) $display("FAIL rst_data got %h exp 0", bus.data_o); else passed++;
    total++; if (bus.ready_o !== 4'h0) $display("FAIL rst_ready got %h exp 0", bus.ready_o); else passed++;
    total++; if (bus.drain_o !== 4'h0) $display("FAIL rst_drain got %h exp 0", bus.drain_o); else passed++;
    total++; if (bus.drain_done_o !== 1'b0) $display("FAIL rst_done got %0h exp 0", bus.drain_done_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rst_busy got %0h exp 0", bus.busy_o); else passed++;
    total++; if (bus.gate_o !== 1'b1) $display("FAIL rst_gate_hi got %0h exp 1", bus.gate_o); else passed++;
    bus.gate_i = 4'b0000;
    #1;
    total++; if (bus.gate_o !== 1'b0) $display("FAIL rst_gate_lo got %0h exp 0", bus.gate_o); else passed++;
    rst = 1'b0;
  endtask
  task automatic test_single();
    logic [31:0] beats [3] = '{32'hA1, 32'hA2, 32'hA3};
    do_reset();
    set_hdr(2, 8'd2, 8'd4, 8'd1);
    bus.gate_i = 4'b0100;
    bus.id_v_i = 4'b0100;
    #1;
    total++; if (bus.ready_o !== 4'h0) $display("FAIL single_idle_ready got %h exp 0", bus.ready_o); else passed++;
    step();
    total++; if (bus.v_o !== 1'b1) $display("FAIL single_hdr_v got %0h exp 1", bus.v_o); else passed++;
    total++; if (bus.data_o !== 32'h00020401) $display("FAIL single_hdr_data got %h exp 00020401", bus.data_o); else passed++;
    total++; if (bus.ready_o !== 4'b0100) $display("FAIL single_hdr_ready got %h exp 4", bus.ready_o); else passed++;
    total++; if (bus.busy_o !== 1'b1) $display("FAIL single_busy got %0h exp 1", bus.busy_o); else passed++;
    step();
    bus.id_v_i = '0;
    bus.v_i = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      bus.data_i[2*32 +: 32] = beats[b];
      bus.last_i = b == 2 ? 4'b0100 : 4'b0000;
      #1;
      total++; if (bus.data_o !== beats[b]) $display("FAIL single_beat%0d got %h exp %h", b, bus.data_o, beats[b]); else passed++;
      total++; if (bus.last_o !== (b == 2)) $display("FAIL single_last%0d got %0h exp %0h", b, bus.last_o, b == 2); else passed++;
      total++; if (bus.ready_o !== 4'b0100) $display("FAIL single_ready%0d got %h exp 4", b, bus.ready_o); else passed++;
      step();
    end
    clear_inputs();
    #1;
    total++; if (bus.v_o !== 1'b0) $display("FAIL single_end_v got %0h exp 0", bus.v_o); else passed++;
    total++; if (bus.ready_o !== 4'h0) $display("FAIL single_end_ready got %h exp 0", bus.ready_o); else passed++;
  endtask
  task automatic test_round_robin();
    int order [4] = '{0, 1, 3, 0};
    logic [31:0] hdrs [4] = '{32'h00100001, 32'h00110001, 32'h00120001, 32'h00130001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_hdr(i, 8'(8'h10 + i), 8'h00, 8'h01);
      bus.data_i[i*32 +: 32] = 32'hD0 + i;
    end
    bus.id_v_i = 4'b1011; bus.gate_i = 4'hF; bus.v_i = 4'hF; bus.last_i = 4'hF;
    for (int f = 0; f < 4; f++) begin
      #1;
      total++; if (bus.v_o !== 1'b0) $display("FAIL rr%0d_idle_v got %0h exp 0", f, bus.v_o); else passed++;
      step();
      total++; if (bus.data_o !== hdrs[order[f]]) $display("FAIL rr%0d_hdr got %h exp %h", f, bus.data_o, hdrs[order[f]]); else passed++;
      total++; if (bus.ready_o !== 4'(1 << order[f])) $display("FAIL rr%0d_ready got %h exp %h", f, bus.ready_o, 4'(1 << order[f])); else passed++;
      step();
      total++; if (bus.data_o !== 32'hD0 + order[f] || bus.last_o !== 1'b1) $display("FAIL rr%0d_data got %h/%0h exp %h/1", f, bus.data_o, bus.last_o, 32'hD0 + order[f]); else passed++;
      step();
    end
    clear_inputs();
  endtask
  task automatic test_empty();
    do_reset();
    set_hdr(1, 8'd5, 8'd0, 8'd3);
    bus.gate_i = 4'b0010;
    bus.id_v_i = 4'b0010;
    step();
    total++; if (bus.data_o !== 32'h00050003) $display("FAIL empty_hdr got %h exp 00050003", bus.data_o); else passed++;
    step();
    bus.id_v_i = '0;
    #1;
    total++; if (bus.v_o !== 1'b0 || bus.ready_o !== 4'b0010) $display("FAIL empty_data got %0h/%h exp 0/2", bus.v_o, bus.ready_o); else passed++;
    bus.gate_i = '0;
    step();
    total++; if (bus.v_o !== 1'b1 || bus.last_o !== 1'b1) $display("FAIL empty_term_vl got %0h/%0h exp 1/1", bus.v_o, bus.last_o); else passed++;
    total++; if (bus.data_o !== 32'h0 || bus.ready_o !== 4'h0) $display("FAIL empty_term_dr got %h/%h exp 0/0", bus.data_o, bus.ready_o); else passed++;
    step();
    total++; if (bus.v_o !== 1'b0 || bus.busy_o !== 1'b0) $display("FAIL empty_idle got %0h/%0h exp 0/0", bus.v_o, bus.busy_o); else passed++;
  endtask
  task automatic test_drain();
    do_reset();
    bus.drain_req_i = 1'b1;
    step();
    bus.drain_req_i = 1'b0;
    total++; if (bus.drain_o !== 4'hF) $display("FAIL drain_arm got %h exp f", bus.drain_o); else passed++;
    total++; if (bus.gate_o !== 1'b1) $display("FAIL drain_gate got %0h exp 1", bus.gate_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      set_hdr(i, 8'(8'h20 + i), 8'h01, 8'h01);
      bus.data_i[i*32 +: 32] = 32'hC0 + i;
      bus.gate_i = 4'(1 << i); bus.id_v_i = 4'(1 << i); bus.v_i = 4'(1 << i); bus.last_i = 4'(1 << i);
      bus.drain_req_i = i == 0;
      #1;
      total++; if (bus.drain_o !== 4'(4'hF << (i + 1))) $display("FAIL drain%0d_mask got %h exp %h", i, bus.drain_o, 4'(4'hF << (i + 1))); else passed++;
      step();
      bus.drain_req_i = 1'b0;
      total++; if (bus.data_o !== 32'h00200101 + (i << 16)) $display("FAIL drain%0d_hdr got %h exp %h", i, bus.data_o, 32'h00200101 + (i << 16)); else passed++;
      step();
      total++; if (bus.data_o !== 32'hC0 + i || bus.last_o !== 1'b1) $display("FAIL drain%0d_data got %h/%0h exp %h/1", i, bus.data_o, bus.last_o, 32'hC0 + i); else passed++;
      step();
      bus.gate_i = '0; bus.id_v_i = '0; bus.v_i = '0; bus.last_i = '0;
      #1;
      total++; if (bus.drain_done_o !== (i == 3)) $display("FAIL drain%0d_done got %0h exp %0h", i, bus.drain_done_o, i == 3); else passed++;
    end
    step();
    total++; if (bus.drain_done_o !== 1'b0 || bus.gate_o !== 1'b0) $display("FAIL drain_after got %0h/%0h exp 0/0", bus.drain_done_o, bus.gate_o); else passed++;
    total++; if (bus.drain_o !== 4'h0) $display("FAIL drain_after_mask got %h exp 0", bus.drain_o); else passed++;
  endtask
  task automatic test_backpressure();
    do_reset();
    set_hdr(3, 8'd7, 8'd1, 8'd2);
    bus.gate_i = 4'b1000;
    bus.id_v_i = 4'b1000;
    bus.ready_i = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.v_o !== 1'b1 || bus.data_o !== 32'h00070102) $display("FAIL bp_hdr%0d got %0h/%h exp 1/00070102", k, bus.v_o, bus.data_o); else passed++;
      step();
    end
    bus.ready_i = 1'b1;
    #1;
    total++; if (bus.ready_o !== 4'b1000) $display("FAIL bp_hdr_ready got %h exp 8", bus.ready_o); else passed++;
    step();
    bus.id_v_i = '0; bus.gate_i = '0; bus.ready_i = 1'b0;
    #1;
    total++; if (bus.v_o !== 1'b0) $display("FAIL bp_no_dup got %0h exp 0", bus.v_o); else passed++;
    step();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.v_o !== 1'b1 || bus.last_o !== 1'b1 || bus.data_o !== 32'h0) $display("FAIL bp_term%0d got %0h/%0h/%h exp 1/1/0", k, bus.v_o, bus.last_o, bus.data_o); else passed++;
      step();
    end
    bus.ready_i = 1'b1;
    step();
    total++; if (bus.v_o !== 1'b0 || bus.busy_o !== 1'b0) $display("FAIL bp_idle got %0h/%0h exp 0/0", bus.v_o, bus.busy_o); else passed++;
  endtask
  task automatic test_reset_mid();
    do_reset();
    set_hdr(1, 8'd9, 8'd0, 8'd1);
    set_hdr(3, 8'd11, 8'd0, 8'd1);
    bus.gate_i = 4'b0010;
    bus.id_v_i = 4'b0010;
    step();
    step();
    bus.id_v_i = '0; bus.v_i = 4'b0010; bus.data_i[1*32 +: 32] = 32'h55;
    #1;
    total++; if (bus.v_o !== 1'b1 || bus.data_o !== 32'h55) $display("FAIL rm_data got %0h/%h exp 1/55", bus.v_o, bus.data_o); else passed++;
    rst = 1'b1;
    step();
    total++; if (bus.v_o !== 1'b0 || bus.last_o !== 1'b0 || bus.data_o !== 32'h0) $display("FAIL rm_out got %0h/%0h/%h exp 0/0/0", bus.v_o, bus.last_o, bus.data_o); else passed++;
    total++; if (bus.ready_o !== 4'h0 || bus.busy_o !== 1'b0 || bus.drain_o !== 4'h0) $display("FAIL rm_ctl got %h/%0h/%h exp 0/0/0", bus.ready_o, bus.busy_o, bus.drain_o); else passed++;
    rst = 1'b0;
    bus.v_i = '0; bus.gate_i = 4'b1010; bus.id_v_i = 4'b1010;
    step();
    total++; if (bus.ready_o !== 4'b0010 || bus.data_o !== 32'h00090001) $display("FAIL rm_regrant got %h/%h exp 2/00090001", bus.ready_o, bus.data_o); else passed++;
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_empty();
    test_drain();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
